trip_release_ctrl: RTL and testbench
====================================

TRIP_RELEASE_CTRL -- requirements
Module: trip_release_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of trip event counter trip_cnt.
REQ-002 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: trig  in  1  one-clk sample strobe, same strobe that drives the trip glitch filter.
REQ-005 SHALL have port: NofClear  in  4  consecutive clean trig samples required before release.
REQ-006 SHALL have port: trip_in  in  1  latched trip from the glitch filter; 1 = fault.
REQ-007 SHALL have port: sigIn  in  1  raw fault level; 1 = fault present.
REQ-008 SHALL have port: clr_req  in  1  operator clear request, one-clk pulse.
REQ-009 SHALL have port: filt_rst  out  1  one-clk active-high synchronous reset pulse to the glitch filter.
REQ-010 SHALL have port: permit_out  out  1  1 = permit, 0 = tripped or clearing.
REQ-011 SHALL have port: clr_ack  out  1  one-clk pulse on return to ARMED.
REQ-012 SHALL have port: clr_nak  out  1  one-clk pulse when a clear attempt aborts.
REQ-013 SHALL have port: state  out  2  00 ARMED, 01 TRIPPED, 10 CLEARING, 11 unused.
REQ-014 SHALL have port: trip_cnt  out  CNT_W  saturating count of ARMED->TRIPPED transitions.
REQ-015 SHALL have port: trip_ts  out  32  trig-count timestamp of the last ARMED->TRIPPED transition.

Function
REQ-016 SHALL register all outputs; no combinational input-to-output path.
REQ-017 SHALL, in ARMED with trip_in=1, enter TRIPPED, drive permit_out=0 from the same edge and increment trip_cnt, saturating at 2^CNT_W-1.
REQ-018 SHALL ignore clr_req in ARMED and CLEARING.
REQ-019 SHALL, in TRIPPED with clr_req=1, pulse filt_rst for exactly one clk, clear clear_cnt to 0 and enter CLEARING; trip_in on that same clk does not block acceptance.
REQ-020 SHALL, in CLEARING, on trig=1 with sigIn=0, increment 4-bit clear_cnt, saturating at 15.
REQ-021 SHALL, in CLEARING, on trig=1 with sigIn=1, pulse clr_nak and return to TRIPPED.
REQ-022 SHALL, in CLEARING with trip_in=1 on any clk after the filt_rst clk, pulse clr_nak and return to TRIPPED without incrementing trip_cnt.
REQ-023 SHALL, in CLEARING with clear_cnt >= NofClear and no abort condition on that clk, enter ARMED, set permit_out=1 and pulse clr_ack.
REQ-024 SHALL give abort (REQ-021/022) priority over release (REQ-023) on the same clk.
REQ-025 SHALL, with NofClear=0, release on the clk after the filt_rst clk if no abort condition is present.
REQ-026 SHALL sample NofClear on every clk; a change during CLEARING takes effect immediately.
REQ-027 SHALL treat encoding 11 as illegal and recover to TRIPPED on the next clk with permit_out=0.

Reset
REQ-028 SHALL on reset=0 asynchronously force state=TRIPPED, permit_out=0, filt_rst=0, clr_ack=0, clr_nak=0, clear_cnt=0, trip_cnt=0 and trip_ts=0; permit requires an explicit clear after power-up.
REQ-029 SHALL release reset synchronously to clk; reset asserted mid-CLEARING aborts with no clr_ack or clr_nak pulse.

Configuration
REQ-030 SHALL, with TRIP_TIMESTAMP_EN defined, keep a free-running 32-bit trig counter (wraps 0xFFFFFFFF->0) and load it into trip_ts on each ARMED->TRIPPED transition.
REQ-031 SHALL, without TRIP_TIMESTAMP_EN, omit the counter and tie trip_ts to 0.

Verification
REQ-032 SHALL cover: reset release, clr_req, NofClear=3, sigIn=0 for 3 trigs -> filt_rst 1 clk, permit_out=1 and clr_ack at the clk after the third trig.
REQ-033 SHALL cover: ARMED, trip_in rises -> permit_out=0 next edge, state=01, trip_cnt 0->1.
REQ-034 SHALL cover: CLEARING, NofClear=5, sigIn=1 at the 2nd trig -> clr_nak pulse, state=01, permit_out stays 0.
REQ-035 SHALL cover: CLEARING with clear_cnt=NofClear and trip_in=1 on the same clk -> clr_nak, state=01, no clr_ack.
REQ-036 SHALL cover: CNT_W=2, 5 trip/clear cycles -> trip_cnt holds 3.
REQ-037 SHALL cover: TRIP_TIMESTAMP_EN defined, trip after 100 trigs -> trip_ts=100; undefined -> trip_ts=0.

Source files
------------

// File: rtl/trip_release_ctrl.sv
// Trip/release supervisor: latches a filtered trip, then re-arms only after an operator
// clear and NofClear consecutive clean trig samples. Optional macro TRIP_TIMESTAMP_EN adds trip timestamps.
module trip_release_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trig,
    input  logic [3:0]       NofClear,
    input  logic             trip_in,
    input  logic             sigIn,
    input  logic             clr_req,
    output logic             filt_rst,
    output logic             permit_out,
    output logic             clr_ack,
    output logic             clr_nak,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] trip_cnt,
    output logic [31:0]      trip_ts
);

    typedef enum logic [1:0] {
        ARMED    = 2'b00,
        TRIPPED  = 2'b01,
        CLEARING = 2'b10,
        ILLEGAL  = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] TRIP_CNT_MAX  = '1;
    localparam logic [3:0]       CLEAR_CNT_MAX = 4'hF;

    state_t      state_q;
    logic [3:0]  clear_cnt;
    logic        abort_c;
    logic        release_c;
    logic [31:0] ts_load_c;

    // The filt_rst clk is still in CLEARING; trip_in is stale then and release must wait one clk.
    assign abort_c   = (trig && sigIn) || (trip_in && !filt_rst);
    assign release_c = !filt_rst && (clear_cnt >= NofClear);
    assign state     = state_q;

`ifdef TRIP_TIMESTAMP_EN
    logic [31:0] trig_ts_cnt;

    // Free-running trig counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_ts_cnt <= '0;
        end else if (trig) begin
            trig_ts_cnt <= trig_ts_cnt + 32'd1;
        end
    end

    assign ts_load_c = trig_ts_cnt;
`else
    assign ts_load_c = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= TRIPPED;
            permit_out <= 1'b0;
            filt_rst   <= 1'b0;
            clr_ack    <= 1'b0;
            clr_nak    <= 1'b0;
            clear_cnt  <= '0;
            trip_cnt   <= '0;
            trip_ts    <= '0;
        end else begin
            filt_rst <= 1'b0;
            clr_ack  <= 1'b0;
            clr_nak  <= 1'b0;
            case (state_q)
                ARMED: begin
                    permit_out <= 1'b1;
                    if (trip_in) begin
                        state_q    <= TRIPPED;
                        permit_out <= 1'b0;
                        trip_ts    <= ts_load_c;
                        if (trip_cnt != TRIP_CNT_MAX) begin
                            trip_cnt <= trip_cnt + CNT_W'(1);
                        end
                    end
                end
                TRIPPED: begin
                    permit_out <= 1'b0;
                    if (clr_req) begin
                        state_q   <= CLEARING;
                        filt_rst  <= 1'b1;
                        clear_cnt <= '0;
                    end
                end
                CLEARING: begin
                    permit_out <= 1'b0;
                    if (abort_c) begin
                        state_q <= TRIPPED;
                        clr_nak <= 1'b1;
                    end else if (release_c) begin
                        state_q    <= ARMED;
                        permit_out <= 1'b1;
                        clr_ack    <= 1'b1;
                    end else if (trig && (clear_cnt != CLEAR_CNT_MAX)) begin
                        clear_cnt <= clear_cnt + 4'd1;
                    end
                end
                default: begin
                    state_q    <= TRIPPED;
                    permit_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trip_release_ctrl.sv
// Directed bench for trip_release_ctrl; a CNT_W=2 instance shares stimulus to observe saturation.
module tb_trip_release_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig;
    logic [3:0]  nof_clear;
    logic        trip_in;
    logic        sig_in;
    logic        clr_req;

    logic        filt_rst, permit_out, clr_ack, clr_nak;
    logic [1:0]  state;
    logic [7:0]  trip_cnt;
    logic [31:0] trip_ts;

    logic        filt_rst2, permit_out2, clr_ack2, clr_nak2;
    logic [1:0]  state2;
    logic [1:0]  trip_cnt2;
    logic [31:0] trip_ts2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    trip_release_ctrl #(.CNT_W(8)) dut (
        .clk(clk), .reset(reset), .trig(trig), .NofClear(nof_clear), .trip_in(trip_in),
        .sigIn(sig_in), .clr_req(clr_req), .filt_rst(filt_rst), .permit_out(permit_out),
        .clr_ack(clr_ack), .clr_nak(clr_nak), .state(state), .trip_cnt(trip_cnt), .trip_ts(trip_ts)
    );

    trip_release_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .trig(trig), .NofClear(nof_clear), .trip_in(trip_in),
        .sigIn(sig_in), .clr_req(clr_req), .filt_rst(filt_rst2), .permit_out(permit_out2),
        .clr_ack(clr_ack2), .clr_nak(clr_nak2), .state(state2), .trip_cnt(trip_cnt2), .trip_ts(trip_ts2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig(input logic sig);
        trig   = 1'b1;
        sig_in = sig;
        tick();
        trig   = 1'b0;
        sig_in = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; trig = 1'b0; nof_clear = 4'd0; trip_in = 1'b0; sig_in = 1'b0; clr_req = 1'b0;
        repeat (2) tick();
        tests_run++;
        if (state !== 2'b01) begin tests_failed++; $display("FAIL reset_state: got %b want 01", state); end
        tests_run++;
        if ({permit_out, filt_rst, clr_ack, clr_nak} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_outs: got %b want 0000", {permit_out, filt_rst, clr_ack, clr_nak});
        end
        tests_run++;
        if (trip_cnt !== 8'd0 || trip_ts !== 32'd0) begin
            tests_failed++; $display("FAIL reset_cnt: got cnt=%0d ts=%0d want 0 0", trip_cnt, trip_ts);
        end
        reset = 1'b1;
        tick();
        tests_run++;
        if (state !== 2'b01 || permit_out !== 1'b0) begin
            tests_failed++; $display("FAIL reset_release_tripped: got st=%b permit=%b want 01 0", state, permit_out);
        end
    endtask

    task automatic test_clear_release();
        nof_clear = 4'd3;
        pulse_clr();
        tests_run++;
        if (state !== 2'b10 || filt_rst !== 1'b1) begin
            tests_failed++; $display("FAIL clr_accept: got st=%b filt_rst=%b want 10 1", state, filt_rst);
        end
        tick();
        tests_run++;
        if (filt_rst !== 1'b0) begin tests_failed++; $display("FAIL filt_rst_one_clk: got %b want 0", filt_rst); end
        repeat (3) pulse_trig(1'b0);
        tests_run++;
        if (state !== 2'b10 || permit_out !== 1'b0) begin
            tests_failed++; $display("FAIL clr_counting: got st=%b permit=%b want 10 0", state, permit_out);
        end
        tick();
        tests_run++;
        if (state !== 2'b00 || permit_out !== 1'b1 || clr_ack !== 1'b1 || clr_nak !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_release: got st=%b permit=%b ack=%b nak=%b want 00 1 1 0", state, permit_out, clr_ack, clr_nak);
        end
        tick();
        tests_run++;
        if (clr_ack !== 1'b0 || permit_out !== 1'b1) begin
            tests_failed++; $display("FAIL clr_ack_pulse: got ack=%b permit=%b want 0 1", clr_ack, permit_out);
        end
    endtask

    task automatic test_ignore_clr_armed();
        pulse_clr();
        tests_run++;
        if (state !== 2'b00 || filt_rst !== 1'b0) begin
            tests_failed++; $display("FAIL armed_ignore_clr: got st=%b filt_rst=%b want 00 0", state, filt_rst);
        end
    endtask

    task automatic test_trip();
        trip_in = 1'b1;
        tick();
        trip_in = 1'b0;
        tests_run++;
        if (state !== 2'b01 || permit_out !== 1'b0 || trip_cnt !== 8'd1) begin
            tests_failed++; $display("FAIL trip: got st=%b permit=%b cnt=%0d want 01 0 1", state, permit_out, trip_cnt);
        end
    endtask

    task automatic test_nak_sig();
        nof_clear = 4'd5;
        pulse_clr();
        tick();
        pulse_trig(1'b0);
        trig = 1'b1; sig_in = 1'b1;
        tick();
        trig = 1'b0; sig_in = 1'b0;
        tests_run++;
        if (clr_nak !== 1'b1 || state !== 2'b01 || permit_out !== 1'b0 || clr_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL nak_sig: got nak=%b st=%b permit=%b ack=%b want 1 01 0 0", clr_nak, state, permit_out, clr_ack);
        end
        tick();
        tests_run++;
        if (clr_nak !== 1'b0) begin tests_failed++; $display("FAIL nak_pulse: got %b want 0", clr_nak); end
    endtask

    task automatic test_nak_trip_race();
        nof_clear = 4'd2;
        pulse_clr();
        pulse_trig(1'b0);
        pulse_trig(1'b0);
        trip_in = 1'b1;
        tick();
        trip_in = 1'b0;
        tests_run++;
        if (clr_nak !== 1'b1 || clr_ack !== 1'b0 || state !== 2'b01) begin
            tests_failed++; $display("FAIL nak_trip_race: got nak=%b ack=%b st=%b want 1 0 01", clr_nak, clr_ack, state);
        end
        tests_run++;
        if (trip_cnt !== 8'd1) begin tests_failed++; $display("FAIL nak_no_count: got %0d want 1", trip_cnt); end
    endtask

    task automatic test_nof_zero();
        nof_clear = 4'd0;
        pulse_clr();
        trip_in = 1'b1;
        tick();
        trip_in = 1'b0;
        tests_run++;
        if (state !== 2'b10 || clr_nak !== 1'b0 || clr_ack !== 1'b0) begin
            tests_failed++; $display("FAIL nof0_hold: got st=%b nak=%b ack=%b want 10 0 0", state, clr_nak, clr_ack);
        end
        tick();
        tests_run++;
        if (state !== 2'b00 || clr_ack !== 1'b1 || permit_out !== 1'b1) begin
            tests_failed++; $display("FAIL nof0_release: got st=%b ack=%b permit=%b want 00 1 1", state, clr_ack, permit_out);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 5; i++) begin
            trip_in = 1'b1;
            tick();
            trip_in = 1'b0;
            pulse_clr();
            repeat (2) tick();
        end
        tests_run++;
        if (trip_cnt2 !== 2'd3) begin tests_failed++; $display("FAIL sat_cnt_w2: got %0d want 3", trip_cnt2); end
        tests_run++;
        if (trip_cnt !== 8'd6) begin tests_failed++; $display("FAIL cnt_w8: got %0d want 6", trip_cnt); end
        tests_run++;
        if (state !== 2'b00 || state2 !== 2'b00) begin
            tests_failed++; $display("FAIL sat_rearmed: got %b/%b want 00/00", state, state2);
        end
    endtask

    task automatic test_reset_mid_clear();
        trip_in = 1'b1;
        tick();
        trip_in = 1'b0;
        pulse_clr();
        #1 reset = 1'b0;
        #1;
        tests_run++;
        if (state !== 2'b01 || permit_out !== 1'b0 || filt_rst !== 1'b0 || trip_cnt !== 8'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got st=%b permit=%b filt=%b cnt=%0d want 01 0 0 0", state, permit_out, filt_rst, trip_cnt);
        end
        tick();
        tests_run++;
        if (clr_ack !== 1'b0 || clr_nak !== 1'b0) begin
            tests_failed++; $display("FAIL reset_no_pulse: got ack=%b nak=%b want 0 0", clr_ack, clr_nak);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_timestamp();
        logic [31:0] exp_ts;
`ifdef TRIP_TIMESTAMP_EN
        exp_ts = 32'd100;
`else
        exp_ts = 32'd0;
`endif
        nof_clear = 4'd0;
        pulse_clr();
        repeat (2) tick();
        repeat (100) pulse_trig(1'b0);
        trip_in = 1'b1;
        tick();
        trip_in = 1'b0;
        tests_run++;
        if (state !== 2'b01 || trip_cnt !== 8'd1) begin
            tests_failed++; $display("FAIL ts_trip: got st=%b cnt=%0d want 01 1", state, trip_cnt);
        end
        tests_run++;
        if (trip_ts !== exp_ts) begin tests_failed++; $display("FAIL trip_ts: got %0d want %0d", trip_ts, exp_ts); end
    endtask

    initial begin
        test_reset();
        test_clear_release();
        test_ignore_clr_armed();
        test_trip();
        test_nak_sig();
        test_nak_trip_race();
        test_nof_zero();
        test_saturation();
        test_reset_mid_clear();
        test_timestamp();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
